// File: rtl/nn_host_bridge.sv
// Host-side initiator for the accelerator memory-mapped port: forwards upstream write
// commands under busy back-pressure and streams readback blocks out through a 2-entry FIFO.
module nn_host_bridge #(
  parameter int MM_DEPTH = 16,
  parameter int MM_SIZE  = 32,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [MM_DEPTH-1:0] cmd_addr,
  input  logic [MM_SIZE-1:0]  cmd_data,
  input  logic                cmd_last,
  input  logic                rd_start,
  input  logic [MM_DEPTH-1:0] rd_base,
  input  logic [CNT_W-1:0]    rd_count,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [MM_SIZE-1:0]  res_data,
  output logic                res_last,
  output logic                nn_write_enable,
  output logic [MM_DEPTH-1:0] nn_write_addr,
  output logic [MM_SIZE-1:0]  nn_write_data,
  input  logic                nn_busy,
  output logic [MM_DEPTH-1:0] nn_read_addr,
  input  logic [MM_SIZE-1:0]  nn_read_data,
  output logic                load_done,
  output logic                rd_done,
  output logic [CNT_W-1:0]    wr_count,
  output logic                state_busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, READ = 2'd2} state_t;

  localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [MM_DEPTH-1:0] ADDR_ONE = {{(MM_DEPTH-1){1'b0}}, 1'b1};

  state_t               state_r;
  logic [CNT_W-1:0]     wr_count_r;
  logic [CNT_W-1:0]     count_r;
  logic [CNT_W-1:0]     issued_r;
  logic [MM_DEPTH-1:0]  rd_addr_r;
  logic                 in_flight_r;
  logic                 in_flight_last_r;
  logic [MM_SIZE-1:0]   fifo_data_r [2];
  logic                 fifo_last_r [2];
  logic                 rd_ptr_r;
  logic                 wr_ptr_r;
  logic [1:0]           fifo_cnt_r;

  logic                 cmd_ready_s;
  logic                 cmd_fire_s;
  logic                 res_valid_s;
  logic                 res_last_s;
  logic                 res_fire_s;
  logic                 start_s;
  logic                 issue_s;
  logic [2:0]           occ_s;

  // Command acceptance decode; held off while reset is asserted
  always_comb begin
    cmd_ready_s = 1'b0;
    if (!reset) begin
      cmd_ready_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    cmd_ready_s = !nn_busy && !rd_start;
        LOAD:    cmd_ready_s = !nn_busy;
        default: cmd_ready_s = 1'b0;
      endcase
    end
  end

  assign cmd_fire_s  = cmd_valid && cmd_ready_s;
  assign res_valid_s = (fifo_cnt_r != 2'd0);
  assign res_last_s  = fifo_last_r[rd_ptr_r];
  assign res_fire_s  = res_valid_s && res_ready;
  assign start_s     = (state_r == IDLE) && rd_start && (rd_count != {CNT_W{1'b0}});

  // nn_read_addr always holds the next address; the memory samples it on the issue edge,
  // so the word lands one edge later and occupancy after this cycle's pop bounds the FIFO.
  assign occ_s   = {1'b0, fifo_cnt_r} + {2'b00, in_flight_r} - {2'b00, res_fire_s};
  assign issue_s = (state_r == READ) && (issued_r < count_r) && (occ_s < 3'd2);

  assign cmd_ready       = cmd_ready_s;
  assign nn_write_enable = cmd_fire_s;
  assign nn_write_addr   = cmd_addr;
  assign nn_write_data   = cmd_data;
  assign load_done       = cmd_fire_s && cmd_last;
  assign res_valid       = res_valid_s;
  assign res_data        = fifo_data_r[rd_ptr_r];
  assign res_last        = res_last_s;
  assign rd_done         = res_fire_s && res_last_s;
  assign nn_read_addr    = rd_addr_r;
  assign wr_count        = wr_count_r;
  assign state_busy      = (state_r != IDLE);

  // Control FSM, write counter, read issue pipeline and result FIFO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r          <= IDLE;
      wr_count_r       <= {CNT_W{1'b0}};
      count_r          <= {CNT_W{1'b0}};
      issued_r         <= {CNT_W{1'b0}};
      rd_addr_r        <= {MM_DEPTH{1'b0}};
      in_flight_r      <= 1'b0;
      in_flight_last_r <= 1'b0;
      fifo_data_r[0]   <= {MM_SIZE{1'b0}};
      fifo_data_r[1]   <= {MM_SIZE{1'b0}};
      fifo_last_r[0]   <= 1'b0;
      fifo_last_r[1]   <= 1'b0;
      rd_ptr_r         <= 1'b0;
      wr_ptr_r         <= 1'b0;
      fifo_cnt_r       <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r   <= READ;
            count_r   <= rd_count;
            issued_r  <= {CNT_W{1'b0}};
            rd_addr_r <= rd_base;
          end else if (cmd_fire_s) begin
            wr_count_r <= CNT_ONE;
            state_r    <= cmd_last ? IDLE : LOAD;
          end
        end
        LOAD: begin
          if (cmd_fire_s) begin
            if (wr_count_r != CNT_MAX) begin
              wr_count_r <= wr_count_r + CNT_ONE;
            end
            if (cmd_last) begin
              state_r <= IDLE;
            end
          end
        end
        READ: begin
          if (res_fire_s && res_last_s) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase

      if (issue_s) begin
        issued_r         <= issued_r + CNT_ONE;
        rd_addr_r        <= rd_addr_r + ADDR_ONE;
        in_flight_last_r <= (issued_r == count_r - CNT_ONE);
      end
      in_flight_r <= issue_s;

      if (in_flight_r) begin
        fifo_data_r[wr_ptr_r] <= nn_read_data;
        fifo_last_r[wr_ptr_r] <= in_flight_last_r;
        wr_ptr_r              <= !wr_ptr_r;
      end
      if (res_fire_s) begin
        rd_ptr_r <= !rd_ptr_r;
      end
      fifo_cnt_r <= fifo_cnt_r + {1'b0, in_flight_r} - {1'b0, res_fire_s};
    end
  end

endmodule

// File: tb/tb_nn_host_bridge.sv
// Directed self-checking bench for nn_host_bridge with a registered memory model (word[a] = a*7).
module tb_nn_host_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_last;
  logic        rd_start;
  logic [15:0] rd_base;
  logic [15:0] rd_count;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_last;
  logic        nn_write_enable;
  logic [15:0] nn_write_addr;
  logic [31:0] nn_write_data;
  logic        nn_busy;
  logic [15:0] nn_read_addr;
  logic [31:0] nn_read_data;
  logic        load_done;
  logic        rd_done;
  logic [15:0] wr_count;
  logic        state_busy;

  int checks = 0;
  int errors = 0;

  nn_host_bridge dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_last(cmd_last),
    .rd_start(rd_start), .rd_base(rd_base), .rd_count(rd_count),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .nn_write_enable(nn_write_enable), .nn_write_addr(nn_write_addr),
    .nn_write_data(nn_write_data), .nn_busy(nn_busy),
    .nn_read_addr(nn_read_addr), .nn_read_data(nn_read_data),
    .load_done(load_done), .rd_done(rd_done), .wr_count(wr_count), .state_busy(state_busy)
  );

  always #5 clk = ~clk;

  // Accelerator output memory: registered read, data one cycle after the address
  always @(posedge clk) nn_read_data <= {16'h0000, nn_read_addr} * 32'd7;

  task automatic test_reset;
    reset = 1'b0; cmd_valid = 1'b0; cmd_addr = 16'h0; cmd_data = 32'h0; cmd_last = 1'b0;
    rd_start = 1'b0; rd_base = 16'h0; rd_count = 16'h0; res_ready = 1'b0; nn_busy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b exp 0", cmd_ready); end
    checks++; if (res_valid !== 1'b0 || load_done !== 1'b0 || rd_done !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got valid=%b ld=%b rd=%b exp 0", res_valid, load_done, rd_done); end
    checks++; if (nn_read_addr !== 16'h0 || wr_count !== 16'h0 || state_busy !== 1'b0) begin
      errors++; $display("FAIL reset_regs got addr=%h wc=%h busy=%b exp 0", nn_read_addr, wr_count, state_busy); end
    @(negedge clk); reset = 1'b1; #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_load;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = 16'h0010 + i[15:0]; cmd_data = 32'h0000_00A0 + i; cmd_last = (i == 3);
      #1;
      checks++; if (nn_write_enable !== 1'b1 || nn_write_addr !== 16'h0010 + i[15:0] || nn_write_data !== 32'h0000_00A0 + i) begin
        errors++; $display("FAIL load_write%0d got en=%b a=%h d=%h exp en=1 a=%h d=%h", i, nn_write_enable,
                           nn_write_addr, nn_write_data, 16'h0010 + i[15:0], 32'h0000_00A0 + i); end
      checks++; if (load_done !== (i == 3)) begin errors++; $display("FAIL load_done%0d got %b exp %b", i, load_done, (i == 3)); end
      if (i > 0) begin
        checks++; if (wr_count !== i[15:0] || state_busy !== 1'b1) begin
          errors++; $display("FAIL load_count%0d got wc=%0d busy=%b exp wc=%0d busy=1", i, wr_count, state_busy, i); end
      end
    end
    @(negedge clk); cmd_valid = 1'b0; cmd_last = 1'b0; #1;
    checks++; if (wr_count !== 16'd4 || state_busy !== 1'b0 || load_done !== 1'b0) begin
      errors++; $display("FAIL load_end got wc=%0d busy=%b ld=%b exp 4 0 0", wr_count, state_busy, load_done); end
  endtask

  task automatic test_busy;
    int sent = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      nn_busy = (c >= 2 && c < 5);
      cmd_valid = 1'b1; cmd_addr = 16'h0020 + sent[15:0]; cmd_data = 32'h0000_00B0 + sent; cmd_last = (sent == 5);
      #1;
      checks++; if (cmd_ready !== !nn_busy || nn_write_enable !== !nn_busy) begin
        errors++; $display("FAIL busy_gate%0d got rdy=%b en=%b exp %b", c, cmd_ready, nn_write_enable, !nn_busy); end
      if (!nn_busy) begin
        checks++; if (nn_write_addr !== 16'h0020 + sent[15:0] || load_done !== (sent == 5)) begin
          errors++; $display("FAIL busy_write%0d got a=%h ld=%b exp a=%h ld=%b", sent, nn_write_addr, load_done,
                             16'h0020 + sent[15:0], (sent == 5)); end
        sent++;
      end
    end
    @(negedge clk); cmd_valid = 1'b0; cmd_last = 1'b0; nn_busy = 1'b0; #1;
    checks++; if (wr_count !== 16'd6 || state_busy !== 1'b0) begin
      errors++; $display("FAIL busy_end got wc=%0d busy=%b exp 6 0", wr_count, state_busy); end
  endtask

  task automatic test_readback;
    logic [31:0] exp_w;
    @(negedge clk); rd_start = 1'b1; rd_base = 16'h0003; rd_count = 16'd5; res_ready = 1'b1; #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rb_start_ready got %b exp 0", cmd_ready); end
    @(negedge clk); rd_start = 1'b0; #1;
    checks++; if (nn_read_addr !== 16'h0003 || res_valid !== 1'b0 || state_busy !== 1'b1) begin
      errors++; $display("FAIL rb_e0 got addr=%h v=%b busy=%b exp 0003 0 1", nn_read_addr, res_valid, state_busy); end
    @(negedge clk); #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rb_e1_valid got %b exp 0", res_valid); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      exp_w = 32'(7 * (3 + k));
      checks++; if (res_valid !== 1'b1 || res_data !== exp_w) begin
        errors++; $display("FAIL rb_word%0d got v=%b d=%0d exp v=1 d=%0d", k, res_valid, res_data, exp_w); end
      checks++; if (res_last !== (k == 4) || rd_done !== (k == 4)) begin
        errors++; $display("FAIL rb_last%0d got last=%b done=%b exp %b", k, res_last, rd_done, (k == 4)); end
    end
    @(negedge clk); #1;
    checks++; if (res_valid !== 1'b0 || state_busy !== 1'b0) begin
      errors++; $display("FAIL rb_end got v=%b busy=%b exp 0 0", res_valid, state_busy); end
  endtask

  task automatic test_backpressure_wrap;
    logic [15:0] a;
    int got = 0;
    @(negedge clk); rd_start = 1'b1; rd_base = 16'hFFFE; rd_count = 16'd4; res_ready = 1'b0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      rd_start = 1'b0;
      res_ready = (c >= 6) ? c[0] : 1'b0;
      #1;
      a = 16'hFFFE + got[15:0];
      if (res_valid) begin
        checks++; if (res_data !== {16'h0000, a} * 32'd7 || res_last !== (got == 3)) begin
          errors++; $display("FAIL bp_word%0d got d=%h last=%b exp d=%h last=%b", got, res_data, res_last,
                             {16'h0000, a} * 32'd7, (got == 3)); end
        if (res_ready) begin
          checks++; if (rd_done !== (got == 3)) begin errors++; $display("FAIL bp_done%0d got %b exp %b", got, rd_done, (got == 3)); end
          got++;
        end
      end
      if (c == 5) begin
        checks++; if (res_valid !== 1'b1 || nn_read_addr !== 16'h0000 || res_data !== 32'h0006_FFF2) begin
          errors++; $display("FAIL bp_stall got v=%b addr=%h d=%h exp 1 0000 0006fff2", res_valid, nn_read_addr, res_data); end
      end
    end
    checks++; if (got !== 4) begin errors++; $display("FAIL bp_timeout got %0d words exp 4", got); end
    @(negedge clk); #1;
    checks++; if (state_busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL bp_end got busy=%b v=%b exp 0 0", state_busy, res_valid); end
  endtask

  task automatic test_conflicts;
    int got = 0;
    @(negedge clk);
    rd_start = 1'b1; rd_base = 16'h0010; rd_count = 16'd2; res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 16'h0055; cmd_data = 32'h0000_0055; cmd_last = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0 || nn_write_enable !== 1'b0 || load_done !== 1'b0) begin
      errors++; $display("FAIL cf_same_cycle got rdy=%b en=%b ld=%b exp 0 0 0", cmd_ready, nn_write_enable, load_done); end
    @(negedge clk); rd_start = 1'b0; #1;
    checks++; if (state_busy !== 1'b1 || cmd_ready !== 1'b0 || nn_write_enable !== 1'b0) begin
      errors++; $display("FAIL cf_read_cmd got busy=%b rdy=%b en=%b exp 1 0 0", state_busy, cmd_ready, nn_write_enable); end
    cmd_valid = 1'b0; cmd_last = 1'b0;
    for (int c = 0; c < 10 && got < 2; c++) begin
      @(negedge clk); res_ready = 1'b1; #1;
      if (res_valid) begin
        checks++; if (res_data !== 32'(7 * (16 + got))) begin
          errors++; $display("FAIL cf_word%0d got %0d exp %0d", got, res_data, 7 * (16 + got)); end
        got++;
      end
    end
    checks++; if (got !== 2 || wr_count !== 16'd6) begin
      errors++; $display("FAIL cf_drain got words=%0d wc=%0d exp 2 6", got, wr_count); end
    @(negedge clk); rd_start = 1'b1; rd_count = 16'd0; res_ready = 1'b0; #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL cf_zero_ready got %b exp 0", cmd_ready); end
    @(negedge clk); rd_start = 1'b0; #1;
    checks++; if (state_busy !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cf_zero_ignored got busy=%b v=%b rdy=%b exp 0 0 1", state_busy, res_valid, cmd_ready); end
  endtask

  task automatic test_reset_mid_read;
    int got = 0;
    @(negedge clk); rd_start = 1'b1; rd_base = 16'h0020; rd_count = 16'd6; res_ready = 1'b1;
    for (int c = 0; c < 12 && got < 2; c++) begin
      @(negedge clk); rd_start = 1'b0; #1;
      if (res_valid) begin
        checks++; if (res_data !== 32'(7 * (32 + got))) begin
          errors++; $display("FAIL rst_word%0d got %0d exp %0d", got, res_data, 7 * (32 + got)); end
        got++;
      end
    end
    checks++; if (got !== 2) begin errors++; $display("FAIL rst_timeout got %0d words exp 2", got); end
    #1; reset = 1'b0; #1;
    checks++; if (res_valid !== 1'b0 || nn_read_addr !== 16'h0 || state_busy !== 1'b0) begin
      errors++; $display("FAIL rst_async got v=%b addr=%h busy=%b exp 0 0000 0", res_valid, nn_read_addr, state_busy); end
    checks++; if (cmd_ready !== 1'b0 || rd_done !== 1'b0 || wr_count !== 16'h0) begin
      errors++; $display("FAIL rst_async_ctl got rdy=%b done=%b wc=%0d exp 0 0 0", cmd_ready, rd_done, wr_count); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checks++; if (res_valid !== 1'b0 || rd_done !== 1'b0 || state_busy !== 1'b0) begin
        errors++; $display("FAIL rst_after%0d got v=%b done=%b busy=%b exp 0 0 0", c, res_valid, rd_done, state_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_busy();
    test_readback();
    test_backpressure_wrap();
    test_conflicts();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_host_bridge.md
# nn_host_bridge

Host-side initiator for the accelerator's memory-mapped port. It converts an upstream command stream into accelerator writes, honouring the accelerator's `busy` back-pressure. On request, it reads a block of result words from the accelerator's output memory and streams them downstream with valid/ready flow control. It sits between the system interconnect and the accelerator top level, driving that block's write and read ports.

## Interface
Parameters:
- MM_DEPTH, 16, address width of the accelerator port
- MM_SIZE, 32, data width of the accelerator port
- CNT_W, 16, width of the read count and write counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  upstream write command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_addr  in  MM_DEPTH  target address
- cmd_data  in  MM_SIZE  write data
- cmd_last  in  1  marks the final command of a load
- rd_start  in  1  single-cycle readback request
- rd_base  in  MM_DEPTH  first output-memory address, sampled with rd_start
- rd_count  in  CNT_W  number of words to read, sampled with rd_start
- res_valid  out  1  result word valid
- res_ready  in  1  downstream accepts result
- res_data  out  MM_SIZE  result word
- res_last  out  1  marks the final word of a readback
- nn_write_enable  out  1  accelerator write strobe
- nn_write_addr  out  MM_DEPTH  accelerator write address
- nn_write_data  out  MM_SIZE  accelerator write data
- nn_busy  in  1  accelerator input FIFO full
- nn_read_addr  out  MM_DEPTH  accelerator read address, registered
- nn_read_data  in  MM_SIZE  accelerator read data, valid one cycle after nn_read_addr
- load_done  out  1  one-cycle pulse when cmd_last is accepted
- rd_done  out  1  one-cycle pulse when the last result word is accepted
- wr_count  out  CNT_W  writes in the current or most recent load
- state_busy  out  1  high whenever the state is not IDLE

## Operation
- The state machine has three states: IDLE, LOAD, READ.
- IDLE:
  - If rd_start is high and rd_count != 0, latch base and count, then go to READ.
  - Otherwise, an accepted command clears wr_count to 1 and goes to LOAD, or stays in IDLE with load_done pulsed if cmd_last is also set.
  - rd_start with rd_count == 0 is ignored.
- LOAD: each accepted command increments wr_count. wr_count saturates at all-ones.
- Accepting cmd_last pulses load_done and returns the block to IDLE.
- cmd_ready = (state is IDLE or LOAD) & !nn_busy & !(state is IDLE & rd_start).
- The write path is combinational pass-through:
  - nn_write_enable = cmd_valid & cmd_ready
  - nn_write_addr = cmd_addr
  - nn_write_data = cmd_data
- READ issues one read per cycle while (fifo_occupancy + in_flight) < 2 and issued < count.
  - Addresses are rd_base + i modulo 2^MM_DEPTH, so wrap-around is permitted.
  - in_flight is 0 or 1.
- Returned data is written into a 2-entry result FIFO tagged with last = (i == count-1). The FIFO head drives res_data, res_valid and res_last.
- READ exits to IDLE when the last-tagged word is accepted. rd_done pulses in that same cycle (combinational with the handshake).
- rd_start outside IDLE and cmd_valid in READ are both ignored; cmd_ready is 0 in READ.

## Timing
- Reset values:
  - All registers are cleared: state IDLE, wr_count 0, FIFO empty, nn_read_addr 0.
  - res_valid, load_done and rd_done are 0.
  - cmd_ready follows its equation with state IDLE. It is forced to 0 while reset is asserted.
- Reset during LOAD or READ aborts immediately: in-flight read data is discarded, the FIFO is emptied, and no done pulse is produced.
- Readback latency: if rd_start is sampled at edge E0, nn_read_addr = rd_base from E0. Data is captured at E2 and res_valid is high from E2.
- With res_ready held high, the block sustains one result per cycle.
- While res_ready is low, at most 2 words are buffered and issue stalls. No data is lost or duplicated.
- res_data, res_last and res_valid hold stable while res_valid & !res_ready.
- If nn_busy rises, cmd_ready falls in the same cycle, so no write is issued while busy is high.

## Test plan
- Load, no back-pressure: 4 commands (addr 0x10..0x13, data 0xA0..0xA3, last on 4th) with nn_busy=0 -> four consecutive nn_write_enable pulses with matching addr/data, load_done on the 4th, wr_count=4, state IDLE.
- Busy stall: nn_busy high for 3 cycles mid-load -> cmd_ready=0 and no nn_write_enable during those cycles; resumes the next cycle after busy falls; wr_count still matches the commands sent.
- Readback: rd_base=0x3, rd_count=5, res_ready=1, memory model word[a]=a*7 -> res_data 21,28,35,42,49 on 5 consecutive cycles starting 2 cycles after rd_start; res_last and rd_done on the 5th.
- Back-pressure and wrap: rd_base=0xFFFE, rd_count=4, res_ready toggling 1/0 -> addresses FFFE,FFFF,0000,0001; outputs in order with no drop or duplicate; never more than 2 words buffered.
- Conflicts: rd_start and cmd_valid in the same IDLE cycle -> READ entered, command not accepted. rd_start with rd_count=0 -> ignored. cmd_valid during READ -> cmd_ready=0.
- Async reset asserted mid-READ after 2 of 6 words -> outputs reach reset values without a clock edge; after release, state IDLE, res_valid=0, no rd_done.
